// File: rtl/clk_period_meter.sv
// Measures the period of a slow asynchronous clock in clk cycles, averaged over
// 2^AVG_LOG2 rising-edge intervals; reports the truncated mean or a timeout.
module clk_period_meter #(
    parameter int CNT_WIDTH = 16,
    parameter int AVG_LOG2  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 meas_clk,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 timeout,
    output logic [CNT_WIDTH-1:0] period
);

    localparam int ACC_W = CNT_WIDTH + AVG_LOG2;
    localparam int EC_W  = AVG_LOG2 + 1;
    localparam logic [EC_W-1:0] LAST_EDGE = EC_W'((1 << AVG_LOG2) - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_EDGE,
        MEASURE,
        DONE
    } state_t;

    state_t state, state_next;

    logic sync1, sync2, sync3;
    logic meas_edge;

    logic [CNT_WIDTH-1:0] wait_cnt;
    logic [ACC_W-1:0]     acc;
    logic [ACC_W-1:0]     acc_inc;
    logic [EC_W-1:0]      edge_cnt;

    logic clear_cnt;
    logic load_ok;
    logic load_to;

    // Two-flop synchronizer plus one flop for rising-edge detection; the
    // constant latency drops out of edge-to-edge interval measurements.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= meas_clk;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign meas_edge = sync2 & ~sync3;
    assign acc_inc   = acc + ACC_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // An Nth edge takes priority over accumulator saturation in the same cycle,
    // so a sum of exactly all-ones is still a valid result.
    always_comb begin
        state_next = state;
        clear_cnt  = 1'b0;
        load_ok    = 1'b0;
        load_to    = 1'b0;
        busy       = (state != IDLE);
        done       = (state == DONE);
        case (state)
            IDLE: begin
                if (start) begin
                    clear_cnt  = 1'b1;
                    state_next = WAIT_EDGE;
                end
            end
            WAIT_EDGE: begin
                if (meas_edge) begin
                    state_next = MEASURE;
                end else if (wait_cnt == '1) begin
                    load_to    = 1'b1;
                    state_next = DONE;
                end
            end
            MEASURE: begin
                if (meas_edge && (edge_cnt == LAST_EDGE)) begin
                    load_ok    = 1'b1;
                    state_next = DONE;
                end else if (acc_inc == '1) begin
                    load_to    = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Counters and result registers; period/timeout load on entry to DONE so
    // they are already valid while done is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
            acc      <= '0;
            edge_cnt <= '0;
            period   <= '0;
            timeout  <= 1'b0;
        end else begin
            if (clear_cnt) begin
                wait_cnt <= '0;
                acc      <= '0;
                edge_cnt <= '0;
            end else if (state == WAIT_EDGE) begin
                if (meas_edge) begin
                    acc      <= '0;
                    edge_cnt <= '0;
                end else begin
                    wait_cnt <= wait_cnt + CNT_WIDTH'(1);
                end
            end else if (state == MEASURE) begin
                acc <= acc_inc;
                if (meas_edge) begin
                    edge_cnt <= edge_cnt + EC_W'(1);
                end
            end

            if (load_ok) begin
                period  <= acc_inc[ACC_W-1:AVG_LOG2];
                timeout <= 1'b0;
            end else if (load_to) begin
                period  <= '1;
                timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_clk_period_meter.sv
// Self-checking bench for clk_period_meter: directed and randomized meas_clk
// interval patterns compared against an arithmetic model of the averaging rules.
module tb_clk_period_meter;

    localparam int CW  = 10;
    localparam int AVG = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          meas_clk = 1'b0;
    logic          start = 1'b0;
    logic          start0 = 1'b0;
    logic          busy, done, timeout;
    logic [CW-1:0] period;
    logic          busy0, done0, timeout0;
    logic [CW-1:0] period0;

    int n_assert = 0;
    int n_fail   = 0;

    int done_cnt = 0;
    int done_cnt0 = 0;
    logic cap_busy, cap_busy0;

    int ivq[$];

    always #5 clk = ~clk;

    clk_period_meter #(.CNT_WIDTH(CW), .AVG_LOG2(AVG)) dut (
        .clk(clk), .rst(rst), .meas_clk(meas_clk), .start(start),
        .busy(busy), .done(done), .timeout(timeout), .period(period)
    );

    clk_period_meter #(.CNT_WIDTH(CW), .AVG_LOG2(0)) dut0 (
        .clk(clk), .rst(rst), .meas_clk(meas_clk), .start(start0),
        .busy(busy0), .done(done0), .timeout(timeout0), .period(period0)
    );

    // Count done pulses (a stretched pulse counts more than once).
    always @(negedge clk) begin
        if (done) begin
            done_cnt = done_cnt + 1;
            cap_busy = busy;
        end
        if (done0) begin
            done_cnt0 = done_cnt0 + 1;
            cap_busy0 = busy0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: the result is the sum of the first 2^a intervals after the
    // reference edge, shifted right by a, unless it exceeds the accumulator.
    task automatic model(input int a, output logic exp_to, output int exp_per);
        longint sum;
        longint limit;
        sum = 0;
        for (int i = 0; i < (1 << a); i++) sum += ivq[i];
        limit = (longint'(1) << (CW + a)) - 1;
        if (sum > limit) begin
            exp_to  = 1'b1;
            exp_per = (1 << CW) - 1;
        end else begin
            exp_to  = 1'b0;
            exp_per = int'(sum >> a);
        end
    endtask

    // Drives a rise, then one rise after each interval in ivq; ends right
    // after setting the final rise.
    task automatic drive_rises(input int lead);
        int hi;
        meas_clk = 1'b0;
        repeat (lead) tick();
        foreach (ivq[i]) begin
            meas_clk = 1'b1;
            hi = ivq[i] / 2;
            repeat (hi) tick();
            meas_clk = 1'b0;
            repeat (ivq[i] - hi) tick();
        end
        meas_clk = 1'b1;
    endtask

    task automatic applyStimulus(input string tag, input bit on0, input int lead);
        int base, lat, a, exp_per, now_cnt;
        logic exp_to;
        logic obs_to, obs_busy;
        logic [CW-1:0] obs_per;
        a = on0 ? 0 : AVG;
        model(a, exp_to, exp_per);
        base = on0 ? done_cnt0 : done_cnt;
        if (on0) start0 = 1'b1;
        else start = 1'b1;
        tick();
        start  = 1'b0;
        start0 = 1'b0;
        drive_rises(lead);
        lat = 0;
        while (((on0 ? done_cnt0 : done_cnt) == base) && lat < 64) begin
            tick();
            lat++;
        end
        repeat (2) tick();
        meas_clk = 1'b0;
        repeat (6) tick();
        now_cnt  = on0 ? done_cnt0 : done_cnt;
        obs_to   = on0 ? timeout0 : timeout;
        obs_per  = on0 ? period0 : period;
        obs_busy = on0 ? cap_busy0 : cap_busy;
        checkOutput($sformatf("%s.done_count", tag), now_cnt - base, 1);
        checkOutput($sformatf("%s.timeout", tag), obs_to, exp_to);
        checkOutput($sformatf("%s.period", tag), obs_per, exp_per);
        checkOutput($sformatf("%s.busy_at_done", tag), obs_busy, 1);
        if (!exp_to)
            checkOutput($sformatf("%s.latency_3to4", tag), (lat >= 3 && lat <= 4), 1);
    endtask

    initial begin
        int base, n;

        // Reset with meas_clk high so the power-on edge pulse appears later.
        rst = 1'b1;
        meas_clk = 1'b1;
        repeat (5) tick();
        checkOutput("reset.busy", busy, 0);
        checkOutput("reset.done", done, 0);
        checkOutput("reset.period", period, 0);
        checkOutput("reset.timeout", timeout, 0);
        checkOutput("reset.busy0", busy0, 0);
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (i % 5 == 0) meas_clk = ~meas_clk;
            tick();
        end
        meas_clk = 1'b0;
        repeat (5) tick();
        checkOutput("idle.done_count", done_cnt, 0);
        checkOutput("idle.done_count0", done_cnt0, 0);
        checkOutput("idle.busy", busy, 0);
        checkOutput("idle.period", period, 0);
        checkOutput("idle.timeout", timeout, 0);

        // busy rises the cycle after start is sampled.
        checkOutput("start.busy_before", busy, 0);
        ivq = '{1000, 1000, 1000, 1000};
        applyStimulus("nominal", 1'b0, 7);

        ivq = '{10, 11, 10, 11};
        applyStimulus("avg_trunc", 1'b0, 3);

        ivq = '{11};
        applyStimulus("single_avg0", 1'b1, 4);

        for (int i = 0; i < 6; i++) begin
            ivq.delete();
            for (int k = 0; k < 4; k++) ivq.push_back(int'($urandom_range(4, 300)));
            applyStimulus("random", 1'b0, int'($urandom_range(0, 20)));
        end
        for (int i = 0; i < 2; i++) begin
            ivq = '{int'($urandom_range(4, 1023))};
            applyStimulus("random_avg0", 1'b1, int'($urandom_range(0, 20)));
        end

        ivq = '{1024, 1024, 1024, 1023};
        applyStimulus("sat_edge_wins", 1'b0, 2);
        ivq = '{1024, 1024, 1024, 1024};
        applyStimulus("sat_timeout", 1'b0, 2);
        ivq = '{1023};
        applyStimulus("avg0_max", 1'b1, 2);
        ivq = '{1024};
        applyStimulus("avg0_timeout", 1'b1, 2);
        ivq = '{1100, 1100, 1100, 1100};
        applyStimulus("slow_timeout", 1'b0, 5);
        ivq = '{100, 100, 100, 100};
        applyStimulus("after_timeout", 1'b0, 5);

        // No edges at all: done 2^CW cycles after entering WAIT_EDGE.
        meas_clk = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("start.busy_after", busy, 1);
        n = 0;
        while (done !== 1'b1 && n < 2000) begin
            tick();
            n++;
        end
        checkOutput("wait_to.cycles", n, 1 << CW);
        checkOutput("wait_to.timeout", timeout, 1);
        checkOutput("wait_to.period", period, (1 << CW) - 1);
        tick();
        checkOutput("wait_to.done_pulse", done, 0);
        repeat (5) tick();

        // start held high for 50 cycles yields a single measurement.
        base = done_cnt;
        start = 1'b1;
        repeat (50) tick();
        start = 1'b0;
        ivq = '{40, 40, 40, 40};
        drive_rises(0);
        repeat (10) tick();
        meas_clk = 1'b0;
        checkOutput("hold.period", period, 40);
        repeat (1100) tick();
        checkOutput("hold.done_count", done_cnt - base, 1);

        // start during the DONE cycle is ignored.
        base = done_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        ivq = '{20, 20, 20, 20};
        drive_rises(3);
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checkOutput("done_start.seen", done, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("done_start.busy", busy, 0);
        repeat (2) tick();
        meas_clk = 1'b0;
        repeat (10) tick();
        checkOutput("done_start.busy_later", busy, 0);
        checkOutput("done_start.done_count", done_cnt - base, 1);
        checkOutput("done_start.period", period, 20);

        // Reset mid-MEASURE: no done, outputs cleared, then a clean measurement.
        base = done_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        ivq = '{50, 50};
        drive_rises(2);
        repeat (10) tick();
        rst = 1'b1;
        tick();
        checkOutput("mid_rst.busy", busy, 0);
        checkOutput("mid_rst.period", period, 0);
        checkOutput("mid_rst.timeout", timeout, 0);
        rst = 1'b0;
        meas_clk = 1'b0;
        repeat (100) tick();
        checkOutput("mid_rst.done_count", done_cnt - base, 0);
        ivq = '{30, 31, 32, 33};
        applyStimulus("after_rst", 1'b0, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
